// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath (window generator and conv_3x3).
//   DEF_PIX_W   default pixel width
//   KERNEL_DIM  window edge length
//   WIN_*       flat window indices, row-major (TL=0 .. BR=8, MC=4 is the centre)
//   win_idx()   (row, col) -> flat window index
package conv_pkg;

  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned KERNEL_DIM = 3;

  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TC = 1;
  localparam int unsigned WIN_TR = 2;
  localparam int unsigned WIN_ML = 3;
  localparam int unsigned WIN_MC = 4;
  localparam int unsigned WIN_MR = 5;
  localparam int unsigned WIN_BL = 6;
  localparam int unsigned WIN_BC = 7;
  localparam int unsigned WIN_BR = 8;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * KERNEL_DIM + c;
  endfunction

endpackage

// File: rtl/conv_window_3x3_gen_if.sv
// Stream bundle of the 3x3 window generator.
//   in_valid/in_ready/in_data    raster-order pixel input
//   out_valid/out_ready          window handshake
//   win0..win8                   window pixels, row-major
//   frame_done                   pulse on the handshake of the last window of a frame
// Modports: master = window generator, slave = pixel source / window consumer side.
interface conv_window_3x3_gen_if #(
  parameter int unsigned PIX_W = conv_pkg::DEF_PIX_W
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic             frame_done;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, win0, win1, win2, win3, win4, win5, win6, win7, win8,
           frame_done
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, win0, win1, win2, win3, win4, win5, win6, win7, win8,
           frame_done
  );
endinterface

// File: rtl/conv_line_buffer.sv
// DEPTH-deep delay line built on a circular-pointer RAM: while en is high, dout is the
// din value written DEPTH enables earlier. The RAM itself is never cleared.
//   clk, rst  clock and synchronous active-high reset (pointer only)
//   en        shift enable
//   din       data in
//   dout      data delayed by DEPTH enabled cycles
module conv_line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Read-before-write on the same slot gives exactly DEPTH cycles of delay.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_3x3_gen.sv
// 3x3 sliding-window generator: turns a raster-order pixel stream into every fully populated
// 3x3 window (no padding), one window per completing pixel, with valid/ready on both sides.
//   clk, rst  clock and synchronous active-high reset
//   bus       conv_window_3x3_gen_if.master (pixel input, window output, frame_done)
module conv_window_3x3_gen
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input logic                   clk,
  input logic                   rst,
  conv_window_3x3_gen_if.master bus
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned NWIN  = KERNEL_DIM * KERNEL_DIM;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             out_valid_q;
  logic             last_q;
  logic [PIX_W-1:0] win_q [NWIN];
  logic [PIX_W-1:0] lb1_out, lb2_out;
  logic             accept, col_last, row_last, completes;

  // The window register doubles as the output register, so it may only move when the
  // held window has been taken (or there is none).
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign col_last     = (col_q == COL_W'(IMG_W - 1));
  assign row_last     = (row_q == ROW_W'(IMG_H - 1));
  assign completes    = (col_q >= COL_W'(KERNEL_DIM - 1)) && (row_q >= ROW_W'(KERNEL_DIM - 1));

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (bus.in_data),
    .dout (lb1_out)
  );

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      for (int unsigned i = 0; i < NWIN; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      out_valid_q <= completes;
      last_q      <= completes && col_last && row_last;
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
      // Shift left one column, new column = {row r-2, row r-1, row r}.
      for (int unsigned r = 0; r < KERNEL_DIM; r++) begin
        for (int unsigned c = 0; c < KERNEL_DIM - 1; c++) begin
          win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
        end
      end
      win_q[WIN_TR] <= lb2_out;
      win_q[WIN_MR] <= lb1_out;
      win_q[WIN_BR] <= bus.in_data;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = out_valid_q && bus.out_ready && last_q;

  assign bus.win0 = win_q[WIN_TL];
  assign bus.win1 = win_q[WIN_TC];
  assign bus.win2 = win_q[WIN_TR];
  assign bus.win3 = win_q[WIN_ML];
  assign bus.win4 = win_q[WIN_MC];
  assign bus.win5 = win_q[WIN_MR];
  assign bus.win6 = win_q[WIN_BL];
  assign bus.win7 = win_q[WIN_BC];
  assign bus.win8 = win_q[WIN_BR];

endmodule

// File: tb/tb_conv_window_3x3_gen.sv
// Directed bench for conv_window_3x3_gen: a 4x4 instance driven from a window table and
// hand-written stall/reset/back-to-back sequences, plus a default 28x28 instance checked
// against an arithmetic window model.
module tb_conv_window_3x3_gen;

  typedef struct packed {
    logic [71:0] w;   // {win0, ..., win8}
    logic        fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  conv_window_3x3_gen_if #(.PIX_W(8)) b4 ();
  conv_window_3x3_gen_if #(.PIX_W(8)) b28 ();

  conv_window_3x3_gen #(
    .PIX_W (8),
    .IMG_W (4),
    .IMG_H (4)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  conv_window_3x3_gen #(
    .PIX_W (8),
    .IMG_W (28),
    .IMG_H (28)
  ) u_dut28 (
    .clk (clk),
    .rst (rst),
    .bus (b28)
  );

  vec_t exp_tab [4];
  vec_t got_q [$];
  int   stray_fd4  = 0;
  int   stray_fd28 = 0;
  int   k28        = 0;
  logic rnd_done;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack4();
    return {b4.win0, b4.win1, b4.win2, b4.win3, b4.win4, b4.win5, b4.win6, b4.win7, b4.win8};
  endfunction

  function automatic logic [71:0] add_off(input logic [71:0] w, input logic [7:0] off);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = w[i*8 +: 8] + off;
    return r;
  endfunction

  // Window monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (b4.out_valid && b4.out_ready) got_q.push_back('{w: pack4(), fd: b4.frame_done});
      else if (b4.frame_done) stray_fd4++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b28.out_valid && b28.out_ready) begin
        int r, c;
        logic [71:0] e;
        r = k28 / 26;
        c = k28 % 26;
        for (int i = 0; i < 9; i++) e[(8 - i)*8 +: 8] = 8'(((r + i / 3) * 28 + c + i % 3) % 256);
        check($sformatf("win28_%0d", k28),
              {b28.win0, b28.win1, b28.win2, b28.win3, b28.win4, b28.win5, b28.win6, b28.win7,
               b28.win8, b28.frame_done}, {e, (k28 == 675)});
        k28++;
      end else if (b28.frame_done) begin
        stray_fd28++;
      end
    end
  end

  task automatic send4(input logic [7:0] p);
    int n = 0;
    b4.in_valid = 1'b1;
    b4.in_data  = p;
    forever begin
      @(negedge clk);
      if (b4.in_ready) break;
      n++;
      if (n > 200) begin
        tests++;
        failed++;
        $display("FAIL send4_timeout: in_ready stuck at 0 for pixel %0d, required 1", p);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send28(input logic [7:0] p);
    int n = 0;
    b28.in_valid = 1'b1;
    b28.in_data  = p;
    forever begin
      @(negedge clk);
      if (b28.in_ready) break;
      n++;
      if (n > 200) begin
        tests++;
        failed++;
        $display("FAIL send28_timeout: in_ready stuck at 0, required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame4(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        b4.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send4(base + 8'(i));
    end
    b4.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input logic [7:0] off, input int start);
    for (int i = 0; i < 4; i++) begin
      vec_t g, e;
      g = (start + i < got_q.size()) ? got_q[start + i] : '0;
      e = '{w: add_off(exp_tab[i].w, off), fd: exp_tab[i].fd};
      check($sformatf("%s_win%0d", name, start + i), g, e);
    end
  endtask

  task automatic stall_proc();
    int n = 0;
    while (!b4.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_first_valid", 73'(b4.out_valid), 73'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 73'(b4.in_ready), 73'd0);
      check("stall_hold", {pack4(), b4.out_valid}, {exp_tab[0].w, 1'b1});
    end
    @(posedge clk);
    #1;
    b4.out_ready = 1'b1;
  endtask

  initial begin
    exp_tab[0] = '{w: {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10},    fd: 1'b0};
    exp_tab[1] = '{w: {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11},   fd: 1'b0};
    exp_tab[2] = '{w: {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}, fd: 1'b0};
    exp_tab[3] = '{w: {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}, fd: 1'b1};

    rst = 1'b1;
    b4.in_valid  = 1'b0; b4.in_data  = '0; b4.out_ready  = 1'b1;
    b28.in_valid = 1'b0; b28.in_data = '0; b28.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 73'(b4.out_valid), 73'd0);
    check("rst_frame_done", 73'(b4.frame_done), 73'd0);
    check("rst_in_ready", 73'(b4.in_ready), 73'd1);
    check("rst_window", 73'(pack4()), 73'd0);
    check("rst_out_valid28", 73'(b28.out_valid), 73'd0);
    @(posedge clk);
    #1;

    // 1: single frame, consumer always ready
    got_q.delete();
    send_frame4(8'd0, 1'b0);
    drain();
    check("t1_count", 73'(got_q.size()), 73'd4);
    check_frame("t1", 8'd0, 0);

    // 2: consumer stalls 5 cycles at the first window
    got_q.delete();
    b4.out_ready = 1'b0;
    fork
      send_frame4(8'd0, 1'b0);
      stall_proc();
    join
    drain();
    check("t2_count", 73'(got_q.size()), 73'd4);
    check_frame("t2", 8'd0, 0);

    // 3: random input gaps and random consumer readiness
    got_q.delete();
    rnd_done = 1'b0;
    fork
      begin
        send_frame4(8'd0, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          b4.out_ready = 1'($urandom_range(0, 1));
        end
        b4.out_ready = 1'b1;
      end
    join
    drain();
    check("t3_count", 73'(got_q.size()), 73'd4);
    check_frame("t3", 8'd0, 0);

    // 4: two frames back to back
    got_q.delete();
    send_frame4(8'd0, 1'b0);
    send_frame4(8'd100, 1'b0);
    drain();
    check("t4_count", 73'(got_q.size()), 73'd8);
    check_frame("t4a", 8'd0, 0);
    check_frame("t4b", 8'd100, 4);

    // 5: reset after 9 pixels, then a full frame
    for (int i = 0; i < 9; i++) send4(8'(200 + i));
    b4.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_out_valid", 73'(b4.out_valid), 73'd0);
    check("t5_rst_frame_done", 73'(b4.frame_done), 73'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_out_valid", 73'(b4.out_valid), 73'd0);
    check("t5_post_frame_done", 73'(b4.frame_done), 73'd0);
    check("t5_post_in_ready", 73'(b4.in_ready), 73'd1);
    @(posedge clk);
    #1;
    got_q.delete();
    send_frame4(8'd0, 1'b0);
    drain();
    check("t5_count", 73'(got_q.size()), 73'd4);
    check_frame("t5", 8'd0, 0);
    check("t4_t5_stray_fd", 73'(stray_fd4), 73'd0);

    // 6: default 28x28 frame
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) send28(8'((r * 28 + c) % 256));
    end
    b28.in_valid = 1'b0;
    drain();
    check("t6_count", 73'(k28), 73'd676);
    check("t6_stray_fd", 73'(stray_fd28), 73'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
